// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage.
//
// Owns the PC and presents it as the instruction memory address every
// cycle. Memory returns data/valid combinationally in the same cycle. Each
// fetched word is tagged with its PC and pushed into a small FIFO, which
// feeds decode over a valid/ready handshake. A misaligned fetch
// (imem_valid = 0) enqueues a NOP marked as a fault and parks the stage in
// HALT until a redirect arrives. A redirect flushes the queue and restarts
// fetch at redirect_pc.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   DEPTH     queue entries (power of 2, >= 2)
//
// Ports:
//   clock, reset                rising-edge clock, synchronous active-high reset
//   imem_address  out [31:0]    fetch address (the PC register)
//   imem_data     in  [31:0]    instruction word for imem_address
//   imem_valid    in            1 = aligned fetch returned data
//   redirect_valid, redirect_pc flush and restart fetch at redirect_pc
//   out_valid/out_ready         head-of-queue handshake to decode
//   out_instr, out_pc, out_fault head entry fields (NOP/0/0 when empty)
//   stat_fetched, stat_stalls   optional counters
//
// Build option:
//   FETCH_STATS_EN  when defined, stat_fetched counts non-fault pushes and
//                   stat_stalls counts cycles in FETCH with a full queue and
//                   no pop. When undefined both outputs are tied to 0.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stalls
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Queue storage carries data only; occupancy is tracked by count, so the
  // entries need no reset.
  logic [31:0]      q_instr [DEPTH];
  logic [31:0]      q_pc    [DEPTH];
  logic [DEPTH-1:0] q_fault;

  logic push;
  logic pop;

  assign imem_address = pc;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = (state == FETCH) & ~redirect_valid & ((count < DEPTH_C) | pop);

  assign out_instr = out_valid ? q_instr[rd_ptr] : NOP;
  assign out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0000_0000;
  assign out_fault = out_valid ? q_fault[rd_ptr] : 1'b0;

  // ---- queue write: fetched word (or fault NOP) tagged with its PC ----
  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_valid ? imem_data : NOP;
      q_pc[wr_ptr]    <= pc;
      q_fault[wr_ptr] <= ~imem_valid;
    end
  end

  // ---- control: PC, pointers, occupancy and fetch state ----
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= RESET_PC;
      state  <= FETCH;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      // Any handshake this cycle is void; decode discards it.
      pc     <= redirect_pc;
      state  <= FETCH;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (imem_valid) begin
          pc <= pc + 32'd4;
        end else begin
          // Fault entry records the offending PC; fetch parks on it.
          state <= HALT;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_cnt;
  logic [31:0] stalls_cnt;

  // ---- statistics: cleared only by reset, redirects leave them running ----
  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_cnt <= '0;
      stalls_cnt  <= '0;
    end else begin
      if (push & imem_valid) begin
        fetched_cnt <= fetched_cnt + 32'd1;
      end
      if ((state == FETCH) && (count == DEPTH_C) && !pop) begin
        stalls_cnt <= stalls_cnt + 32'd1;
      end
    end
  end

  assign stat_fetched = fetched_cnt;
  assign stat_stalls  = stalls_cnt;
`else
  assign stat_fetched = 32'h0000_0000;
  assign stat_stalls  = 32'h0000_0000;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage; sits directly upstream of the instruction memory and downstream-feeds decode.
- Owns the PC and drives the memory address each cycle; the memory read is combinational, with zero-cycle data/valid return.
- Buffers fetched words in a small FIFO with PC tags. Hands entries to decode over a valid/ready handshake.
- Handles redirects from execute/trap logic and misaligned-fetch faults.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- DEPTH, 4, instruction queue entries; power of 2, >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  32  fetch address; equals the PC register (combinational from register).
- imem_data  in  32  instruction word for imem_address, same cycle.
- imem_valid  in  1  1 = aligned fetch returned data; 0 = misaligned or memory in reset.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC when redirect_valid = 1.
- out_valid  out  1  head entry present.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  head instruction PC.
- out_fault  out  1  head entry is a misaligned-fetch fault.
- stat_fetched  out  32  optional counter (see Optional Feature).
- stat_stalls  out  32  optional counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state:
  - PC = RESET_PC, queue empty (count = 0, rd/wr pointers = 0), state = FETCH.
  - Outputs: out_valid = 0, out_instr = 32'h00000013, out_pc = 0, out_fault = 0, counters = 0.
  - Reset has priority over everything else.
- Output side:
  - out_valid = (count != 0).
  - Head fields come directly from queue storage (registered).
  - When the queue is empty: out_instr = 32'h00000013, out_pc = 0, out_fault = 0.
- Pop: pop = out_valid & out_ready.
- Push condition: push = (state == FETCH) & ~redirect_valid & (count < DEPTH | pop).
  - Full with a simultaneous pop therefore pushes, and count stays at DEPTH.
- Push, imem_valid = 1:
  - Enqueue {imem_data, PC, fault = 0}.
  - PC <= PC + 4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Push, imem_valid = 0:
  - Enqueue {32'h00000013, PC, fault = 1}.
  - PC holds; state <= HALT.
- State machine:
  - FETCH: one word per cycle while there is space. Latency is 1 cycle from address to out_valid when the queue is empty.
  - HALT: no pushes and no PC change. Queue still drains. Exit only by redirect or reset.
- Redirect (redirect_valid = 1):
  - Queue flushed: count = 0, pointers = 0.
  - PC <= redirect_pc; state <= FETCH; no push that cycle.
  - A handshake in the same cycle is void; decode must discard it.
  - Next cycle: out_valid = 0 and imem_address = redirect_pc.
- Count update: count += push - pop, using a (log2(DEPTH)+1)-bit counter; pointers wrap modulo DEPTH.
- Stall-freedom:
  - While PC is aligned and decode is always ready, exactly one entry per cycle, with no gaps and no duplicates.
  - PCs are delivered in strictly sequential order between redirects.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - stat_fetched increments on every push with fault = 0.
  - stat_stalls increments each cycle with state == FETCH, count == DEPTH and pop == 0.
  - Both wrap at 2^32, clear on reset, and are unaffected by redirect.
- Undefined: stat_fetched and stat_stalls are tied to 0; no counter flops are synthesised.

Test Plan:
- Release reset with RESET_PC = 0, out_ready = 1, memory of distinct words -> out_valid = 1 from the 1st cycle after reset; out_pc = 0, 4, 8, ... one per cycle; out_instr = mem[pc>>2].
- Hold out_ready = 0 for 10 cycles (DEPTH = 4) -> queue holds pcs 0x0–0xC, imem_address parks at 0x10, stat_stalls = 6. Then raise out_ready -> pcs 0x0, 0x4, ... with no gap or repeat.
- With 3 entries queued, assert redirect to 0x100 together with a pop -> next cycle out_valid = 0, imem_address = 0x100; following cycle out_pc = 0x100.
- Redirect to 0x102 (imem_valid = 0) -> single entry {instr 0x13, pc 0x102, fault 1}. No further out_valid until redirect to 0x200, then out_pc = 0x200.
- Queue full (count = 4), out_ready = 1 -> pop and push in the same cycle, count stays 4, out_pc advances by 4 each cycle.
- Redirect to 32'hFFFFFFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000. Assert reset mid-stream -> next cycle out_valid = 0, imem_address = RESET_PC, counters = 0.
